// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle: host and sequencer request channels plus the register-bank strobe.
// Pure wiring, no latency of its own.
// Requesters hold valid and their address/data until they see ready at a rising edge.
interface reg_write_arbiter_if;
  logic       h_valid;
  logic       h_ready;
  logic [7:0] h_addr;
  logic [7:0] h_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  // Requester / register-bank side
  modport master (
    output h_valid, h_addr, h_data, s_valid, s_addr, s_data,
    input  h_ready, s_ready, wr_en, wr_addr, wr_data
  );

  // Arbiter side
  modport slave (
    input  h_valid, h_addr, h_data, s_valid, s_addr, s_data,
    output h_ready, s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Arbitrates host and sequencer writes onto the register-bank port, locking the 24-bit frequency group.
// Latency: an accept at edge N gives wr_en during cycle N+1; one write per cycle sustained.
// Backpressure: ready is combinational; the host wins in IDLE, and only the lock owner is ready while locked.
module reg_write_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_write_arbiter_if.slave   bus,
  output logic [1:0]           lock_owner,
  output logic                 timeout_pulse,
  output logic [7:0]           drop_count
);

  localparam logic [7:0] ADDR_FREQ_LO = 8'h02;
  localparam logic [7:0] ADDR_FREQ_HI = 8'h04;
  localparam logic [8:0] TIMEOUT      = 9'(LOCK_TIMEOUT);

  // The state encoding doubles as the lock_owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCK_H = 2'b01,
    LOCK_S = 2'b10
  } state_t;

  state_t     state, state_next;
  logic [7:0] timer, timer_next;
  logic       pulse_next;

  logic       h_rdy, s_rdy;
  logic       h_acc, s_acc, acc;
  logic [7:0] acc_addr, acc_data;
  logic       writable;

  // Ready depends only on the current state and the host valid.
  always_comb begin
    h_rdy = 1'b0;
    s_rdy = 1'b0;
    case (state)
      IDLE: begin
        h_rdy = 1'b1;
        s_rdy = ~bus.h_valid;
      end
      LOCK_H:  h_rdy = 1'b1;
      LOCK_S:  s_rdy = 1'b1;
      default: ;
    endcase
  end

  assign bus.h_ready = h_rdy;
  assign bus.s_ready = s_rdy;

  // At most one requester is ready-and-valid in any state, so a simple mux picks the accepted write.
  assign h_acc    = bus.h_valid & h_rdy;
  assign s_acc    = bus.s_valid & s_rdy;
  assign acc      = h_acc | s_acc;
  assign acc_addr = h_acc ? bus.h_addr : bus.s_addr;
  assign acc_data = h_acc ? bus.h_data : bus.s_data;

  // Only control, frequency, duty and volume reach the bank; status and holes are swallowed.
  always_comb begin
    writable = 1'b0;
    case (acc_addr)
      8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06: writable = 1'b1;
      default:                                  writable = 1'b0;
    endcase
  end

  // Lock FSM next state: enter on a freq-low write, leave on freq-high or after a silent timeout.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        timer_next = 8'd0;
        if (acc && acc_addr == ADDR_FREQ_LO) begin
          state_next = h_acc ? LOCK_H : LOCK_S;
        end
      end
      LOCK_H, LOCK_S: begin
        if (acc) begin
          // Owner activity always beats an expiring timer.
          timer_next = 8'd0;
          if (acc_addr == ADDR_FREQ_HI) begin
            state_next = IDLE;
          end
        end else if ({1'b0, timer} + 9'd1 >= TIMEOUT) begin
          state_next = IDLE;
          timer_next = 8'd0;
          pulse_next = 1'b1;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = 8'd0;
      end
    endcase
  end

  // Lock state, idle timer and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= 8'd0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      timeout_pulse <= pulse_next;
    end
  end

  assign lock_owner = state;

  // Registered write strobe to the bank and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= 8'h00;
      bus.wr_data <= 8'h00;
      drop_count  <= 8'd0;
    end else begin
      bus.wr_en <= acc & writable;
      if (acc && writable) begin
        bus.wr_addr <= acc_addr;
        bus.wr_data <= acc_data;
      end
      if (acc && !writable && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vectors, per-cycle comparison against a behavioural model,
// plus literal expectations for each scenario. LOCK_TIMEOUT is set to 4.
module tb_reg_write_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lock_owner;
  logic       timeout_pulse;
  logic [7:0] drop_count;

  reg_write_arbiter_if bus();

  reg_write_arbiter #(.LOCK_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .lock_owner    (lock_owner),
    .timeout_pulse (timeout_pulse),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 host, 2 sequencer. silent: locked cycles since last owner write.
  int         m_owner, m_silent, m_drops;
  bit         m_wr_en, m_pulse;
  logic [7:0] m_wr_addr, m_wr_data;
  bit         g_h, g_s, any;
  logic [7:0] a, d;

  function automatic bit reg_writable(input logic [7:0] ad);
    return ad inside {8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_silent = 0; m_drops = 0;
      m_wr_en = 0; m_pulse = 0; m_wr_addr = 8'h00; m_wr_data = 8'h00;
    end else begin
      g_h = bus.h_valid && (m_owner != 2);
      g_s = bus.s_valid && (m_owner == 2 || (m_owner == 0 && !bus.h_valid));
      any = g_h || g_s;
      a   = g_h ? bus.h_addr : bus.s_addr;
      d   = g_h ? bus.h_data : bus.s_data;
      m_wr_en = any && reg_writable(a);
      if (m_wr_en) begin m_wr_addr = a; m_wr_data = d; end
      if (any && !reg_writable(a)) m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
      m_pulse = 0;
      if (m_owner == 0) begin
        if (any && a == 8'h02) begin m_owner = g_h ? 1 : 2; m_silent = 0; end
      end else if (any) begin
        m_silent = 0;
        if (a == 8'h04) m_owner = 0;
      end else begin
        m_silent++;
        if (m_silent == TO) begin m_owner = 0; m_silent = 0; m_pulse = 1; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [23:0] log_q[$];   // {owner(8), addr, data} of every observed strobe
  bit          cmp_on = 1'b1;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("h_ready", bus.h_ready, m_owner != 2);
      check("s_ready", bus.s_ready, bus.s_valid ? (m_owner == 2 || (m_owner == 0 && !bus.h_valid))
                                                : (m_owner == 2 || (m_owner == 0 && !bus.h_valid)));
      check("wr_en", bus.wr_en, m_wr_en);
      if (m_wr_en) begin
        check("wr_addr", bus.wr_addr, m_wr_addr);
        check("wr_data", bus.wr_data, m_wr_data);
      end
      check("lock_owner", lock_owner, m_owner);
      check("timeout_pulse", timeout_pulse, m_pulse);
      check("drop_count", drop_count, m_drops);
      if (bus.wr_en) log_q.push_back({6'd0, lock_owner, bus.wr_addr, bus.wr_data});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic host_wr(input logic [7:0] ad, input logic [7:0] dt);
    bit done = 1'b0;
    bus.h_valid = 1'b1; bus.h_addr = ad; bus.h_data = dt;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (bus.h_ready) done = 1'b1;
      tick();
    end
    if (!done) check("host_accept_wait", 0, 1);
    bus.h_valid = 1'b0;
  endtask

  task automatic seq_wr(input logic [7:0] ad, input logic [7:0] dt);
    bus.s_valid = 1'b1; bus.s_addr = ad; bus.s_data = dt;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int k;
    bus.h_valid = 0; bus.h_addr = 0; bus.h_data = 0;
    bus.s_valid = 0; bus.s_addr = 0; bus.s_data = 0;
    tick(); tick();
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 8'h00);
    check("rst_owner", lock_owner, 2'b00);
    check("rst_drop", drop_count, 0);
    rst = 1'b0;
    tick();

    // Single host write
    host_wr(8'h00, 8'h1D);
    check("single_wr_en", bus.wr_en, 1);
    check("single_addr", bus.wr_addr, 8'h00);
    check("single_data", bus.wr_data, 8'h1D);
    check("single_owner", lock_owner, 2'b00);
    tick();

    // Contention in IDLE: host first, sequencer next cycle
    bus.h_valid = 1; bus.h_addr = 8'h05; bus.h_data = 8'h40;
    seq_wr(8'h06, 8'h80);
    #1;
    check("cont_s_ready_low", bus.s_ready, 0);
    check("cont_h_ready", bus.h_ready, 1);
    tick();
    check("cont_first_addr", bus.wr_addr, 8'h05);
    check("cont_first_data", bus.wr_data, 8'h40);
    bus.h_valid = 0;
    tick();
    check("cont_second_en", bus.wr_en, 1);
    check("cont_second_addr", bus.wr_addr, 8'h06);
    check("cont_second_data", bus.wr_data, 8'h80);
    bus.s_valid = 0;
    tick();

    // Atomic frequency group while the host waits with 0x06
    log_q.delete();
    seq_wr(8'h02, 8'hAA);
    tick();
    bus.h_valid = 1; bus.h_addr = 8'h06; bus.h_data = 8'hFF;
    seq_wr(8'h03, 8'hBB);
    #1;
    check("atomic_h_stalled", bus.h_ready, 0);
    tick();
    seq_wr(8'h04, 8'hCC);
    tick();
    bus.s_valid = 0;
    tick();
    bus.h_valid = 0;
    tick(); tick();
    check("atomic_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("atomic_a0", log_q[0][15:8], 8'h02);
      check("atomic_a1", log_q[1][15:8], 8'h03);
      check("atomic_a2", log_q[2][15:8], 8'h04);
      check("atomic_a3", log_q[3][15:8], 8'h06);
      check("atomic_d3", log_q[3][7:0], 8'hFF);
      check("atomic_own0", log_q[0][17:16], 2'b10);
      check("atomic_own1", log_q[1][17:16], 2'b10);
    end

    // Lock timeout with a sequencer write pending
    host_wr(8'h02, 8'h11);
    seq_wr(8'h05, 8'h55);
    k = 0;
    while (!timeout_pulse && k < 20) begin tick(); k++; end
    check("timeout_cycles", k, 4);
    check("timeout_owner", lock_owner, 2'b00);
    check("timeout_s_ready", bus.s_ready, 1);
    tick();
    check("timeout_seq_wr", bus.wr_en, 1);
    check("timeout_seq_addr", bus.wr_addr, 8'h05);
    check("timeout_pulse_once", timeout_pulse, 0);
    bus.s_valid = 0;
    tick();

    // Owner accept on the expiring cycle wins over the timer
    host_wr(8'h02, 8'h21);
    tick(); tick(); tick();
    host_wr(8'h05, 8'h22);
    check("race_no_pulse", timeout_pulse, 0);
    check("race_still_locked", lock_owner, 2'b01);
    host_wr(8'h04, 8'h33);
    check("release_owner", lock_owner, 2'b00);
    tick();

    // Drop filtering and saturation
    host_wr(8'h12, 8'hFF);
    host_wr(8'h07, 8'h42);
    host_wr(8'h01, 8'h00);
    tick();
    check("drop_three", drop_count, 3);
    bus.h_valid = 1; bus.h_addr = 8'h12; bus.h_data = 8'h00;
    for (int i = 0; i < 300; i++) tick();
    bus.h_valid = 0;
    tick();
    check("drop_saturate", drop_count, 255);

    // Reset mid-lock with a sequencer write in flight
    seq_wr(8'h02, 8'h10);
    tick();
    seq_wr(8'h03, 8'h77);
    #1;
    check("pre_rst_owner", lock_owner, 2'b10);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_owner", lock_owner, 2'b00);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_addr", bus.wr_addr, 8'h00);
    bus.s_valid = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    host_wr(8'h00, 8'h01);
    check("post_rst_en", bus.wr_en, 1);
    check("post_rst_addr", bus.wr_addr, 8'h00);
    check("post_rst_data", bus.wr_data, 8'h01);
    tick(); tick();

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
